delay_tap_crossfader: RTL

Downstream consumer of the parallel fixed-length delay lines: accepts all delayed 8-bit tap streams at once and drives one output. Changing the selected tap triggers a linear crossfade over 2^FADE_LOG2 cycles instead of a hard switch, which removes the step discontinuity a plain tap multiplexer produces. Output is registered and sits directly ahead of `uo_out`.

---
 rtl/delay_tap_crossfader_if.sv | 34 +++
 rtl/delay_tap_crossfader.sv | 135 +++++++++++++
 2 files changed

// File: rtl/delay_tap_crossfader_if.sv
// ---------------------------------------------------------------------------
// delay_tap_crossfader_if
//
// Bundles the tap-crossfader data/control signals so producer and consumer
// share one port.
//
//   ena       master -> slave   block enable
//   tap_in    master -> slave   NTAPS packed tap streams, tap t at [t*WIDTH +: WIDTH]
//   sel       master -> slave   requested tap index
//   out_data  slave  -> master  registered mixed sample
//   fading    slave  -> master  high while a crossfade is in progress
//   cur_tap   slave  -> master  tap currently selected (old tap while fading)
// ---------------------------------------------------------------------------
interface delay_tap_crossfader_if #(
    parameter int WIDTH = 8,
    parameter int NTAPS = 4
);
    logic                   ena;
    logic [NTAPS*WIDTH-1:0] tap_in;
    logic [1:0]             sel;
    logic [WIDTH-1:0]       out_data;
    logic                   fading;
    logic [1:0]             cur_tap;

    modport master (
        output ena, tap_in, sel,
        input  out_data, fading, cur_tap
    );

    modport slave (
        input  ena, tap_in, sel,
        output out_data, fading, cur_tap
    );
endinterface

// File: rtl/delay_tap_crossfader.sv
// ---------------------------------------------------------------------------
// delay_tap_crossfader
//
// Takes every delayed tap stream in parallel and drives a single registered
// output. A change of the selected tap runs a linear crossfade over
// 2^FADE_LOG2 cycles instead of switching hard, so the output has no step.
//
// Ports:
//   clock  rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    delay_tap_crossfader_if.slave (ena, tap_in, sel in;
//          out_data, fading, cur_tap out)
// ---------------------------------------------------------------------------
module delay_tap_crossfader #(
    parameter int WIDTH     = 8,
    parameter int NTAPS     = 4,
    parameter int FADE_LOG2 = 4
) (
    input  logic                   clock,
    input  logic                   rst_n,
    delay_tap_crossfader_if.slave  bus
);

    localparam int SUM_W = WIDTH + FADE_LOG2;
    // Fade length L, held in FADE_LOG2+1 bits so that L - cnt never wraps.
    localparam logic [FADE_LOG2:0] FADE_LEN = {1'b1, {FADE_LOG2{1'b0}}};

    typedef enum logic {
        IDLE,
        FADE
    } state_t;

    state_t               state_q;
    logic [FADE_LOG2-1:0] cnt_q;
    logic [1:0]           sel_q;
    logic [1:0]           cur_tap_q;
    logic [1:0]           next_tap_q;
    logic [WIDTH-1:0]     out_q;
    logic                 fading_q;

    // Tap table padded to the full 2-bit selector range; missing taps read 0
    // so no index can fall outside the packed input vector.
    logic [WIDTH-1:0] taps [4];

    for (genvar t = 0; t < 4; t++) begin : g_tap
        if (t < NTAPS) begin : g_live
            assign taps[t] = bus.tap_in[t*WIDTH +: WIDTH];
        end else begin : g_pad
            assign taps[t] = '0;
        end
    end

    logic [WIDTH-1:0]     old_tap;
    logic [WIDTH-1:0]     new_tap;
    logic [FADE_LOG2:0]   w_old;
    logic [SUM_W:0]       prod_old;
    logic [SUM_W-1:0]     prod_new;
    logic [SUM_W-1:0]     fade_sum;
    logic [WIDTH-1:0]     mix;
    logic                 sel_valid;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here unconditionally up front), otherwise synthesis infers a latch.
    always_comb begin
        old_tap   = taps[cur_tap_q];
        new_tap   = taps[next_tap_q];
        w_old     = FADE_LEN - {1'b0, cnt_q};
        prod_old  = (SUM_W+1)'(old_tap) * (SUM_W+1)'(w_old);
        prod_new  = SUM_W'(new_tap) * SUM_W'(cnt_q);
        // The weighted sum never exceeds (2^WIDTH-1)*L, so dropping the
        // extra carry bit loses nothing.
        fade_sum  = SUM_W'(prod_old + {1'b0, prod_new});
        sel_valid = int'(sel_q) < NTAPS;
        mix       = old_tap;
        if (state_q == FADE) begin
            // Truncating shift: no rounding of the blended sample.
            mix = WIDTH'(fade_sum >> FADE_LOG2);
        end
    end

    // NOTE: asynchronous reset reaches every flop here, including mid-fade,
    // so outputs clear immediately without waiting for a clock edge.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            cur_tap_q  <= '0;
            next_tap_q <= '0;
            out_q      <= '0;
            fading_q   <= 1'b0;
        end else if (bus.ena) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            sel_q <= bus.sel;
            out_q <= mix;
            unique case (state_q)
                IDLE: begin
                    // Out-of-range selects are treated as no request.
                    if (sel_valid && (sel_q != cur_tap_q)) begin
                        next_tap_q <= sel_q;
                        cnt_q      <= '0;
                        state_q    <= FADE;
                        fading_q   <= 1'b1;
                    end
                end
                FADE: begin
                    // Select changes during a fade are not latched; the IDLE
                    // cycle that follows picks up any pending request.
                    if (cnt_q == '1) begin
                        cur_tap_q <= next_tap_q;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                        fading_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    fading_q <= 1'b0;
                end
            endcase
        end else begin
            // Disabled: output forced to zero, FSM and sel_q frozen so the
            // fade resumes at the held count.
            out_q <= '0;
        end
    end

    assign bus.out_data = out_q;
    assign bus.fading   = fading_q;
    assign bus.cur_tap  = cur_tap_q;

endmodule
